// File: rtl/ntt_bf_stage_if.sv
// Stream, result and twiddle-ROM signals of one NTT/INTT butterfly stage.
// The slave modport is the stage's view; master is the surrounding datapath.
interface ntt_bf_stage_if #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned LOG_N      = 8
);
    logic                  mode;
    logic                  intt_halve;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  out_last;
    logic                  out_mode;
    logic                  rom_en;
    logic [LOG_N-2:0]      rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    modport slave (
        input  mode, intt_halve, in_valid, in_a, in_b, out_ready, rom_data,
        output in_ready, out_valid, out_a, out_b, out_last, out_mode, rom_en, rom_addr
    );

    modport master (
        output mode, intt_halve, in_valid, in_a, in_b, out_ready, rom_data,
        input  in_ready, out_valid, out_a, out_b, out_last, out_mode, rom_en, rom_addr
    );
endinterface

// File: rtl/ntt_bf_stage.sv
// Self-timed radix-2 butterfly stage: CT for NTT, GS (optionally halved) for INTT,
// with ready/valid backpressure, per-frame mode latching and twiddle addressing.
module ntt_bf_stage #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned Q          = 3329,
    parameter int unsigned LOG_N      = 8,
    parameter int unsigned STAGE      = 0,
    parameter int unsigned MUL_LAT    = 3
) (
    input logic           clk,
    input logic           rst_n,
    ntt_bf_stage_if.slave bus
);
    localparam int unsigned     DW   = DATA_WIDTH;
    localparam int unsigned     CW   = LOG_N - 1;
    localparam int unsigned     PW   = 2 * DATA_WIDTH;
    localparam logic [DW:0]     QX   = (DW + 1)'(Q);
    localparam logic [PW-1:0]   QP   = PW'(Q);
    localparam logic [CW-1:0]   BASE = CW'(1) << STAGE;
    localparam logic [CW-1:0]   LAST = '1;

    function automatic logic [DW-1:0] f_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) s = s - QX;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] f_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + QX - {1'b0, y};
        return s[DW-1:0];
    endfunction

    // Division by two mod Q: odd values borrow one Q so the shift is exact.
    function automatic logic [DW-1:0] f_halve(input logic [DW-1:0] x);
        logic [DW:0] s;
        s = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
        return s[DW:1];
    endfunction

    logic          w_adv, w_acc, w_mode, w_halve;
    logic [DW-1:0] w_pre_c, w_pre_x, w_m, w_c, w_oa, w_ob;

    logic [CW-1:0] r_cnt;
    logic          r_frame_mode, r_frame_halve;
    logic          r_s0_valid, r_s0_mode, r_s0_halve, r_s0_last;
    logic [DW-1:0] r_s0_a, r_s0_b;
    logic          r_s1_valid, r_s1_mode, r_s1_halve, r_s1_last;
    logic [DW-1:0] r_s1_c, r_s1_x, r_s1_w;
    logic          r_mv [MUL_LAT];
    logic          r_mm [MUL_LAT];
    logic          r_mh [MUL_LAT];
    logic          r_ml [MUL_LAT];
    logic [DW-1:0] r_mc [MUL_LAT];
    logic [PW-1:0] r_mp [MUL_LAT];
    logic          r_out_valid, r_out_last, r_out_mode;
    logic [DW-1:0] r_out_a, r_out_b;

    assign w_adv   = !(r_out_valid && !bus.out_ready);
    assign w_acc   = bus.in_valid && w_adv;
    assign w_mode  = (r_cnt == '0) ? bus.mode : r_frame_mode;
    assign w_halve = (r_cnt == '0) ? bus.intt_halve : r_frame_halve;

    assign bus.in_ready  = w_adv;
    assign bus.rom_en    = w_acc;
    assign bus.rom_addr  = BASE + (r_cnt >> (CW - STAGE));
    assign bus.out_valid = r_out_valid;
    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;
    assign bus.out_last  = r_out_last;
    assign bus.out_mode  = r_out_mode;

    // INTT does its add/sub before the multiply, NTT after it.
    assign w_pre_c = r_s0_mode ? f_add(r_s0_a, r_s0_b) : r_s0_a;
    assign w_pre_x = r_s0_mode ? f_sub(r_s0_a, r_s0_b) : r_s0_b;

    assign w_m = DW'(r_mp[MUL_LAT-1] % QP);
    assign w_c = r_mc[MUL_LAT-1];

    always_comb begin
        w_oa = w_c;
        w_ob = w_m;
        if (!r_mm[MUL_LAT-1]) begin
            w_oa = f_add(w_c, w_m);
            w_ob = f_sub(w_c, w_m);
        end else if (r_mh[MUL_LAT-1]) begin
            w_oa = f_halve(w_c);
            w_ob = f_halve(w_m);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_frame_mode  <= 1'b0;
            r_frame_halve <= 1'b0;
            r_s0_valid    <= 1'b0;
            r_s0_mode     <= 1'b0;
            r_s0_halve    <= 1'b0;
            r_s0_last     <= 1'b0;
            r_s0_a        <= '0;
            r_s0_b        <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_mode     <= 1'b0;
            r_s1_halve    <= 1'b0;
            r_s1_last     <= 1'b0;
            r_s1_c        <= '0;
            r_s1_x        <= '0;
            r_s1_w        <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_mv[i] <= 1'b0;
                r_mm[i] <= 1'b0;
                r_mh[i] <= 1'b0;
                r_ml[i] <= 1'b0;
                r_mc[i] <= '0;
                r_mp[i] <= '0;
            end
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_mode    <= 1'b0;
            r_out_a       <= '0;
            r_out_b       <= '0;
        end else if (w_adv) begin
            if (w_acc) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == '0) begin
                    r_frame_mode  <= bus.mode;
                    r_frame_halve <= bus.intt_halve;
                end
            end
            r_s0_valid <= bus.in_valid;
            r_s0_mode  <= w_mode;
            r_s0_halve <= w_halve;
            r_s0_last  <= (r_cnt == LAST);
            r_s0_a     <= bus.in_a;
            r_s0_b     <= bus.in_b;
            // ROM output holds while stalled, so it is still this beat's twiddle here.
            r_s1_valid <= r_s0_valid;
            r_s1_mode  <= r_s0_mode;
            r_s1_halve <= r_s0_halve;
            r_s1_last  <= r_s0_last;
            r_s1_c     <= w_pre_c;
            r_s1_x     <= w_pre_x;
            r_s1_w     <= bus.rom_data;
            r_mv[0]    <= r_s1_valid;
            r_mm[0]    <= r_s1_mode;
            r_mh[0]    <= r_s1_halve;
            r_ml[0]    <= r_s1_last;
            r_mc[0]    <= r_s1_c;
            r_mp[0]    <= PW'(r_s1_x) * PW'(r_s1_w);
            for (int i = 1; i < MUL_LAT; i++) begin
                r_mv[i] <= r_mv[i-1];
                r_mm[i] <= r_mm[i-1];
                r_mh[i] <= r_mh[i-1];
                r_ml[i] <= r_ml[i-1];
                r_mc[i] <= r_mc[i-1];
                r_mp[i] <= r_mp[i-1];
            end
            r_out_valid <= r_mv[MUL_LAT-1];
            r_out_last  <= r_ml[MUL_LAT-1];
            r_out_mode  <= r_mm[MUL_LAT-1];
            r_out_a     <= w_oa;
            r_out_b     <= w_ob;
        end
    end
endmodule

// File: tb/tb_ntt_bf_stage.sv
// Scoreboard bench for ntt_bf_stage: directed butterflies, frame/ROM addressing,
// backpressure hold, mode latching across frames and mid-frame reset.
module tb_ntt_bf_stage;
    localparam int unsigned DW      = 12;
    localparam int unsigned Q       = 3329;
    localparam int unsigned LOG_N   = 8;
    localparam int unsigned STAGE   = 1;
    localparam int unsigned MUL_LAT = 3;
    localparam int          FRAME   = 128;

    typedef struct {
        int a;
        int b;
        bit last;
        bit mode;
        int acc;
        bit chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ntt_bf_stage_if #(.DATA_WIDTH(DW), .LOG_N(LOG_N)) bus ();

    ntt_bf_stage #(
        .DATA_WIDTH(DW),
        .Q(Q),
        .LOG_N(LOG_N),
        .STAGE(STAGE),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   tb_beat = 0;
    int   drv_w = 0;
    bit   f_mode = 1'b0;
    bit   f_halve = 1'b0;
    bit   stall_go = 1'b0;

    bit   mon_stalled = 1'b0;
    int   mon_a, mon_b, mon_l, mon_m;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous twiddle ROM: holds its output when not enabled.
    always @(posedge clk) if (bus.rom_en) bus.rom_data <= drv_w[DW-1:0];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_bf(input int a, input int b, input int w, input bit m,
                                   input bit h, output int oa, output int ob);
        int t;
        if (!m) begin
            t  = (b * w) % Q;
            oa = (a + t) % Q;
            ob = (a - t + Q) % Q;
        end else begin
            oa = (a + b) % Q;
            ob = (((a - b + Q) % Q) * w) % Q;
            if (h) begin
                oa = (oa % 2 == 0) ? oa / 2 : (oa + Q) / 2;
                ob = (ob % 2 == 0) ? ob / 2 : (ob + Q) / 2;
            end
        end
    endfunction

    function automatic int sa(input int i); return (i * 37 + 11) % Q; endfunction
    function automatic int sb(input int i); return (i * 101 + 3) % Q; endfunction
    function automatic int sw(input int i); return (i * 53 + 7) % Q; endfunction

    task automatic send(input int a, input int b, input int w, input bit m, input bit h,
                        input bit use_ref, input int ea, input int eb, input bit lat);
        exp_t e;
        int   g;
        int   oa, ob;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_a       = a[DW-1:0];
        bus.in_b       = b[DW-1:0];
        bus.mode       = m;
        bus.intt_halve = h;
        drv_w          = w;
        #1;
        g = 0;
        while (!bus.in_ready) begin
            if (g >= 50) begin
                $display("FAIL in_ready_timeout: got 0 expected 1 within 50 cycles");
                n_fail++;
                $fatal(1, "stage never became ready");
            end
            @(negedge clk);
            #1;
            g++;
        end
        if (tb_beat == 0) begin
            f_mode  = m;
            f_halve = h;
        end
        chk("rom_en", int'(bus.rom_en), 1);
        chk("rom_addr", int'(bus.rom_addr), (1 << STAGE) + (tb_beat >> (LOG_N - 1 - STAGE)));
        if (use_ref) ref_bf(a, b, w, f_mode, f_halve, oa, ob);
        else begin
            oa = ea;
            ob = eb;
        end
        e.a       = oa;
        e.b       = ob;
        e.last    = (tb_beat == FRAME - 1);
        e.mode    = f_mode;
        e.acc     = cyc + 1;
        e.chk_lat = lat;
        exp_q.push_back(e);
        tb_beat = (tb_beat + 1) % FRAME;
    endtask

    // Monitor: a beat presented with out_ready high is consumed at the next edge.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (mon_stalled) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_a", int'(bus.out_a), mon_a);
                chk("hold_b", int'(bus.out_b), mon_b);
                chk("hold_last", int'(bus.out_last), mon_l);
                chk("hold_mode", int'(bus.out_mode), mon_m);
            end
            mon_stalled = 1'b0;
            if (bus.out_valid) begin
                if (!bus.out_ready) begin
                    mon_stalled = 1'b1;
                    mon_a = int'(bus.out_a);
                    mon_b = int'(bus.out_b);
                    mon_l = int'(bus.out_last);
                    mon_m = int'(bus.out_mode);
                    chk("stall_in_ready", int'(bus.in_ready), 0);
                end else if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got a=%0d b=%0d expected no beat",
                             bus.out_a, bus.out_b);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_a", int'(bus.out_a), mon_e.a);
                    chk("out_b", int'(bus.out_b), mon_e.b);
                    chk("out_last", int'(bus.out_last), int'(mon_e.last));
                    chk("out_mode", int'(bus.out_mode), int'(mon_e.mode));
                    if (mon_e.chk_lat) chk("latency", cyc - mon_e.acc, MUL_LAT + 2);
                end
            end
        end else begin
            mon_stalled = 1'b0;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        wait (stall_go);
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
    end

    initial begin
        int g;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.mode       = 1'b0;
        bus.intt_halve = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_a", int'(bus.out_a), 0);
        chk("rst_out_b", int'(bus.out_b), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_out_mode", int'(bus.out_mode), 0);
        chk("rst_rom_en", int'(bus.rom_en), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 1, NTT; mode input flips at beat 10 and must be ignored.
        send(5, 7, 17, 1'b0, 1'b0, 1'b0, 124, 3215, 1'b1);
        send(3328, 1, 1, 1'b0, 1'b0, 1'b0, 0, 3327, 1'b0);
        send(0, 3328, 3328, 1'b0, 1'b0, 1'b0, 1, 3328, 1'b0);
        for (int i = 3; i < FRAME; i++) begin
            if (i == 20) stall_go = 1'b1;
            send(sa(i), sb(i), sw(i), (i >= 10), 1'b0, 1'b1, 0, 0, 1'b0);
        end

        // Frame 2, INTT back-to-back with frame 1.
        send(5, 7, 17, 1'b1, 1'b0, 1'b0, 12, 3295, 1'b1);
        for (int i = 1; i < FRAME; i++)
            send(sa(i), sb(i), sw(i), (i < 10), 1'b0, 1'b1, 0, 0, 1'b0);

        // Frame 3, INTT with halving, cut short by reset.
        send(5, 7, 17, 1'b1, 1'b1, 1'b0, 6, 3312, 1'b1);
        for (int i = 1; i < 6; i++)
            send(sa(i), sb(i), sw(i), 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        exp_q.delete();
        tb_beat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(9, 4, 2, 1'b0, 1'b0, 1'b0, 17, 1, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;

        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
